// File: rtl/wb_regfile_unit_pkg.sv
// Writeback source codes and datapath constants shared by writeback and decode.
package riscv_wb_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int PEND_W = 2;

  localparam logic [2:0] REG_R7 = 3'd7;

  // Decode emits these codes in the M_WB control field; 101-111 are reserved.
  typedef enum logic [2:0] {
    WB_NONE = 3'b000,
    WB_ALU  = 3'b001,
    WB_MEM  = 3'b010,
    WB_ZPAD = 3'b011,
    WB_PC2  = 3'b100
  } wb_sel_e;

endpackage

// File: rtl/wb_regfile_unit_if.sv
// Writeback, read-port, issue and redirect signals between the pipeline and the register file.
interface wb_regfile_unit_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);

  logic              wb_valid;
  logic [2:0]        wb_sel;
  logic [REG_AW-1:0] wb_dest;
  logic [DATA_W-1:0] wb_alu;
  logic [DATA_W-1:0] wb_mem_data;
  logic [DATA_W-1:0] wb_zero_pad;
  logic [DATA_W-1:0] wb_pc_plus2;
  logic [REG_AW-1:0] rd_addr_a;
  logic [REG_AW-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              hazard_a;
  logic              hazard_b;
  logic              issue_valid;
  logic              issue_writes;
  logic [REG_AW-1:0] issue_dest;
  logic              issue_stall;
  logic              pc_redirect_valid;
  logic [DATA_W-1:0] pc_redirect_target;
  logic [15:0]       retired_count;

  modport master (
    output wb_valid, wb_sel, wb_dest, wb_alu, wb_mem_data, wb_zero_pad, wb_pc_plus2,
    output rd_addr_a, rd_addr_b, issue_valid, issue_writes, issue_dest,
    input  rd_data_a, rd_data_b, hazard_a, hazard_b, issue_stall,
    input  pc_redirect_valid, pc_redirect_target, retired_count
  );

  modport slave (
    input  wb_valid, wb_sel, wb_dest, wb_alu, wb_mem_data, wb_zero_pad, wb_pc_plus2,
    input  rd_addr_a, rd_addr_b, issue_valid, issue_writes, issue_dest,
    output rd_data_a, rd_data_b, hazard_a, hazard_b, issue_stall,
    output pc_redirect_valid, pc_redirect_target, retired_count
  );

endinterface

// File: rtl/wb_regfile_unit_scoreboard.sv
// Per-register pending-write counters; hazard and stall flags are combinational from
// the counters and this cycle's commit, so a retiring write clears its own hazard.
module wb_scoreboard #(
  parameter int REG_AW = 3,
  parameter int PEND_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_commit,
  input  logic [REG_AW-1:0] i_wb_dest,
  input  logic              i_issue_valid,
  input  logic              i_issue_writes,
  input  logic [REG_AW-1:0] i_issue_dest,
  input  logic [REG_AW-1:0] i_rd_addr_a,
  input  logic [REG_AW-1:0] i_rd_addr_b,
  output logic              o_issue_stall,
  output logic              o_hazard_a,
  output logic              o_hazard_b
);

  localparam int NREG = 1 << REG_AW;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0] r_pend [NREG];
  logic [NREG-1:0]   w_inc;
  logic [NREG-1:0]   w_dec;
  logic              w_issue_go;

  always_comb begin
    w_inc         = '0;
    w_dec         = '0;
    // A commit to the same register frees a slot, so a full counter may still accept.
    o_issue_stall = i_issue_valid && i_issue_writes && (r_pend[i_issue_dest] == PEND_MAX) &&
                    !(i_commit && (i_wb_dest == i_issue_dest));
    w_issue_go    = i_issue_valid && i_issue_writes && !o_issue_stall;
    if (w_issue_go) w_inc[i_issue_dest] = 1'b1;
    if (i_commit)   w_dec[i_wb_dest]    = 1'b1;
  end

  assign o_hazard_a = (r_pend[i_rd_addr_a] != '0) &&
                      !(i_commit && (i_wb_dest == i_rd_addr_a) && (r_pend[i_rd_addr_a] == PEND_ONE));
  assign o_hazard_b = (r_pend[i_rd_addr_b] != '0) &&
                      !(i_commit && (i_wb_dest == i_rd_addr_b) && (r_pend[i_rd_addr_b] == PEND_ONE));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) r_pend[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_inc[r] && !w_dec[r]) begin
          r_pend[r] <= r_pend[r] + 1'b1;
        end else if (w_dec[r] && !w_inc[r] && (r_pend[r] != '0)) begin
          r_pend[r] <= r_pend[r] - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_regfile_unit.sv
// Writeback mux, 8x16 register file with write-through read bypass, R7 redirect and retire count.
// Reads are combinational; writes land at the edge; the redirect pulse is one cycle after the R7 commit.
module wb_regfile_unit
  import riscv_wb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int PEND_W = 2
) (
  input  logic           clock,
  input  logic           reset,
  wb_regfile_unit_if.slave bus
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] r_regs [NREG];
  logic              r_redirect_vld;
  logic [DATA_W-1:0] r_redirect_tgt;
  logic [15:0]       r_retired;
  logic              w_commit;
  logic [DATA_W-1:0] w_wb_value;
  logic              w_hit_a;
  logic              w_hit_b;

  always_comb begin
    w_commit   = 1'b0;
    w_wb_value = '0;
    if (bus.wb_valid) begin
      case (bus.wb_sel)
        WB_ALU:  begin w_commit = 1'b1; w_wb_value = bus.wb_alu;      end
        WB_MEM:  begin w_commit = 1'b1; w_wb_value = bus.wb_mem_data; end
        WB_ZPAD: begin w_commit = 1'b1; w_wb_value = bus.wb_zero_pad; end
        WB_PC2:  begin w_commit = 1'b1; w_wb_value = bus.wb_pc_plus2; end
        default: ;
      endcase
    end
  end

  assign w_hit_a       = w_commit && (bus.wb_dest == bus.rd_addr_a);
  assign w_hit_b       = w_commit && (bus.wb_dest == bus.rd_addr_b);
  assign bus.rd_data_a = w_hit_a ? w_wb_value : r_regs[bus.rd_addr_a];
  assign bus.rd_data_b = w_hit_b ? w_wb_value : r_regs[bus.rd_addr_b];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
      r_redirect_vld <= 1'b0;
      r_redirect_tgt <= '0;
      r_retired      <= '0;
    end else begin
      r_redirect_vld <= w_commit && (bus.wb_dest == REG_R7);
      if (w_commit) begin
        r_regs[bus.wb_dest] <= w_wb_value;
        r_retired           <= r_retired + 16'd1;
        if (bus.wb_dest == REG_R7) r_redirect_tgt <= w_wb_value;
      end
    end
  end

  assign bus.pc_redirect_valid  = r_redirect_vld;
  assign bus.pc_redirect_target = r_redirect_tgt;
  assign bus.retired_count      = r_retired;

  wb_scoreboard #(
    .REG_AW (REG_AW),
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clock          (clock),
    .reset          (reset),
    .i_commit       (w_commit),
    .i_wb_dest      (bus.wb_dest),
    .i_issue_valid  (bus.issue_valid),
    .i_issue_writes (bus.issue_writes),
    .i_issue_dest   (bus.issue_dest),
    .i_rd_addr_a    (bus.rd_addr_a),
    .i_rd_addr_b    (bus.rd_addr_b),
    .o_issue_stall  (bus.issue_stall),
    .o_hazard_a     (bus.hazard_a),
    .o_hazard_b     (bus.hazard_b)
  );

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Scoreboard bench: each stimulus cycle pushes the reference model's expected outputs, a monitor compares at negedge.
module tb_wb_regfile_unit;
  import riscv_wb_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  wb_regfile_unit_if #(.DATA_W(16), .REG_AW(3)) bus ();

  wb_regfile_unit #(.DATA_W(16), .REG_AW(3), .PEND_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] rd_a;
    logic [15:0] rd_b;
    logic        haz_a;
    logic        haz_b;
    logic        stall;
    logic        rv;
    logic [15:0] rt;
    logic [15:0] ret;
    bit          chk_comb;
    logic [95:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: architectural state as plain integers.
  int m_regs[8];
  int m_pend[8];
  int m_retired;
  bit m_rv;
  int m_rt;

  task automatic check(input logic [95:0] tag, input string what, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s %s: got %h, expected %h", tag, what, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_comb) begin
          check(e.tag, "rd_data_a", bus.rd_data_a, e.rd_a);
          check(e.tag, "rd_data_b", bus.rd_data_b, e.rd_b);
          check(e.tag, "hazard_a", {15'd0, bus.hazard_a}, {15'd0, e.haz_a});
          check(e.tag, "hazard_b", {15'd0, bus.hazard_b}, {15'd0, e.haz_b});
          check(e.tag, "issue_stall", {15'd0, bus.issue_stall}, {15'd0, e.stall});
        end
        check(e.tag, "redirect_valid", {15'd0, bus.pc_redirect_valid}, {15'd0, e.rv});
        check(e.tag, "redirect_target", bus.pc_redirect_target, e.rt);
        check(e.tag, "retired_count", bus.retired_count, e.ret);
      end
    end
  end

  task automatic clear_stim();
    bus.wb_valid = 1'b0;  bus.wb_sel = 3'd0;  bus.wb_dest = 3'd0;
    bus.wb_alu = 16'd0;   bus.wb_mem_data = 16'd0;
    bus.wb_zero_pad = 16'd0; bus.wb_pc_plus2 = 16'd0;
    bus.rd_addr_a = 3'd0; bus.rd_addr_b = 3'd0;
    bus.issue_valid = 1'b0; bus.issue_writes = 1'b0; bus.issue_dest = 3'd0;
  endtask

  task automatic set_commit(input logic [2:0] sel, input logic [2:0] dst, input logic [15:0] val);
    bus.wb_valid = 1'b1; bus.wb_sel = sel; bus.wb_dest = dst;
    bus.wb_alu = val; bus.wb_mem_data = val; bus.wb_zero_pad = val; bus.wb_pc_plus2 = val;
  endtask

  // Predict this cycle's outputs from the model and current inputs, then advance the model at the edge.
  task automatic step(input logic [95:0] tag);
    exp_t e;
    bit commit, inc, dec_r, inc_r;
    int val, left_a, left_b, left_i;
    int dst, idst, ra, rb;
    dst  = int'(bus.wb_dest);
    idst = int'(bus.issue_dest);
    ra   = int'(bus.rd_addr_a);
    rb   = int'(bus.rd_addr_b);
    commit = bus.wb_valid && (bus.wb_sel inside {[3'd1:3'd4]});
    case (bus.wb_sel)
      3'd1:    val = int'(bus.wb_alu);
      3'd2:    val = int'(bus.wb_mem_data);
      3'd3:    val = int'(bus.wb_zero_pad);
      default: val = int'(bus.wb_pc_plus2);
    endcase
    // Writes still outstanding once this cycle's commit has retired.
    left_a = m_pend[ra]   - ((commit && dst == ra)   ? 1 : 0);
    left_b = m_pend[rb]   - ((commit && dst == rb)   ? 1 : 0);
    left_i = m_pend[idst] - ((commit && dst == idst) ? 1 : 0);
    e.rd_a     = (commit && dst == ra) ? 16'(val) : 16'(m_regs[ra]);
    e.rd_b     = (commit && dst == rb) ? 16'(val) : 16'(m_regs[rb]);
    e.haz_a    = left_a > 0;
    e.haz_b    = left_b > 0;
    e.stall    = bus.issue_valid && bus.issue_writes && (left_i >= 3);
    e.rv       = m_rv;
    e.rt       = 16'(m_rt);
    e.ret      = 16'(m_retired);
    e.chk_comb = !(reset && commit);
    e.tag      = tag;
    inc = bus.issue_valid && bus.issue_writes && !e.stall;
    exp_q.push_back(e);
    @(posedge clock);
    if (reset) begin
      for (int r = 0; r < 8; r++) begin m_regs[r] = 0; m_pend[r] = 0; end
      m_retired = 0; m_rv = 1'b0; m_rt = 0;
    end else begin
      m_rv = commit && dst == 7;
      if (commit) begin
        m_regs[dst] = val;
        m_retired   = (m_retired + 1) % 65536;
        if (dst == 7) m_rt = val;
      end
      for (int r = 0; r < 8; r++) begin
        dec_r = commit && dst == r;
        inc_r = inc && idst == r;
        if (inc_r && !dec_r) m_pend[r] = m_pend[r] + 1;
        else if (dec_r && !inc_r && m_pend[r] > 0) m_pend[r] = m_pend[r] - 1;
      end
    end
    #1;
  endtask

  task automatic read_all(input logic [95:0] tag);
    for (int i = 0; i < 8; i++) begin
      clear_stim();
      bus.rd_addr_a = 3'(i);
      bus.rd_addr_b = 3'(7 - i);
      step(tag);
    end
  endtask

  initial begin
    for (int r = 0; r < 8; r++) begin m_regs[r] = 0; m_pend[r] = 0; end
    m_retired = 0; m_rv = 1'b0; m_rt = 0;
    clear_stim();
    reset = 1'b1;
    @(posedge clock); #1;
    step("reset");
    reset = 1'b0;
    read_all("post_reset");

    clear_stim(); set_commit(3'b001, 3'd3, 16'h1234); bus.rd_addr_a = 3'd3;
    step("alu_r3_byp");
    clear_stim(); bus.rd_addr_a = 3'd3;
    step("alu_r3_reg");

    clear_stim(); bus.wb_sel = 3'b010; bus.wb_dest = 3'd4; bus.wb_mem_data = 16'hBEEF; bus.rd_addr_a = 3'd4;
    step("nvalid_mem");
    clear_stim(); bus.rd_addr_a = 3'd4;
    step("nvalid_chk");
    clear_stim(); set_commit(3'b110, 3'd4, 16'hCAFE); bus.rd_addr_a = 3'd4;
    step("rsvd_sel");
    clear_stim(); bus.rd_addr_a = 3'd4;
    step("rsvd_chk");

    for (int i = 0; i < 4; i++) begin
      clear_stim(); bus.issue_valid = 1'b1; bus.issue_writes = 1'b1; bus.issue_dest = 3'd5; bus.rd_addr_a = 3'd5;
      step("issue_r5");
    end
    clear_stim(); bus.issue_valid = 1'b1; bus.issue_writes = 1'b1; bus.issue_dest = 3'd5;
    set_commit(3'b001, 3'd5, 16'h0555); bus.rd_addr_a = 3'd5;
    step("r5_iss_cmt");
    clear_stim(); bus.issue_valid = 1'b1; bus.issue_writes = 1'b1; bus.issue_dest = 3'd5; bus.rd_addr_a = 3'd5;
    step("r5_full");
    for (int i = 0; i < 3; i++) begin
      clear_stim(); set_commit(3'b010, 3'd5, 16'(16'h0A00 + i)); bus.rd_addr_a = 3'd5; bus.rd_addr_b = 3'd5;
      step("r5_drain");
    end
    clear_stim(); bus.rd_addr_a = 3'd5;
    step("r5_clear");

    clear_stim(); bus.issue_valid = 1'b1; bus.issue_writes = 1'b1; bus.issue_dest = 3'd2; bus.rd_addr_b = 3'd2;
    step("issue_r2");
    clear_stim(); set_commit(3'b011, 3'd2, 16'h7700); bus.rd_addr_b = 3'd2;
    step("cmt_r2");
    clear_stim(); bus.rd_addr_b = 3'd2;
    step("r2_after");

    repeat (300) begin
      clear_stim();
      bus.wb_valid     = ($urandom_range(0, 3) != 0);
      bus.wb_sel       = 3'($urandom_range(0, 7));
      bus.wb_dest      = 3'($urandom_range(0, 7));
      bus.wb_alu       = 16'($urandom);
      bus.wb_mem_data  = 16'($urandom);
      bus.wb_zero_pad  = 16'($urandom);
      bus.wb_pc_plus2  = 16'($urandom);
      bus.rd_addr_a    = 3'($urandom_range(0, 7));
      bus.rd_addr_b    = 3'($urandom_range(0, 7));
      bus.issue_valid  = ($urandom_range(0, 1) != 0);
      bus.issue_writes = ($urandom_range(0, 3) != 0);
      bus.issue_dest   = 3'($urandom_range(0, 7));
      if (bus.wb_valid && (bus.wb_sel inside {[3'd1:3'd4]}) && m_pend[bus.wb_dest] == 0 &&
          bus.issue_dest == bus.wb_dest)
        bus.issue_writes = 1'b0;
      step("random");
    end

    clear_stim(); set_commit(3'b100, 3'd7, 16'h0042); bus.rd_addr_a = 3'd7;
    step("r7_commit");
    clear_stim(); set_commit(3'b001, 3'd1, 16'h5555); bus.rd_addr_a = 3'd1;
    reset = 1'b1;
    step("r7_pulse_rst");
    reset = 1'b0;
    read_all("after_rst");

    repeat (2) @(posedge clock);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
